pipelined_control_unit: RTL and testbench

- Next-generation main decoder for the pipelined MIPS core. It decodes the ID-stage opcode and registers the control word into an ID/EX control register.
- Generates the front-end stall for load-use hazards and for the multi-cycle Booth multiplier. Inserts bubbles on taken-branch flush.
- Sits between the IF/ID register and the EX stage. The datapath's ID/EX data fields share its stall and flush decisions.

---
 rtl/pipelined_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - ID-stage main decoder with ID/EX control register, hazard stall and MUL sequencing
module pipelined_control_unit #(
  parameter int OPCODE_W   = 6,
  parameter int REG_W      = 5,
  parameter int ALUOP_W    = 3,
  parameter int MUL_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                branch_taken,
  output logic                stall,
  output logic                ex_valid,
  output logic                ex_reg_dst,
  output logic                ex_alu_src,
  output logic                ex_mem_to_reg,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_branch,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic [REG_W-1:0]    ex_rt,
  output logic                ex_mul_start,
  output logic                mul_busy
);

  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               w_dec_reg_dst;
  logic               w_dec_alu_src;
  logic               w_dec_mem_to_reg;
  logic               w_dec_reg_write;
  logic               w_dec_mem_read;
  logic               w_dec_mem_write;
  logic               w_dec_branch;
  logic [ALUOP_W-1:0] w_dec_alu_op;
  logic               w_dec_is_mul;

  logic               w_lu;
  logic               w_load;
  logic               w_hold;

  always_comb begin
    w_dec_reg_dst    = 1'b0;
    w_dec_alu_src    = 1'b1;
    w_dec_mem_to_reg = 1'b0;
    w_dec_reg_write  = 1'b1;
    w_dec_mem_read   = 1'b0;
    w_dec_mem_write  = 1'b0;
    w_dec_branch     = 1'b0;
    w_dec_alu_op     = ALUOP_W'(3'b010);
    w_dec_is_mul     = 1'b0;
    case (id_opcode)
      OPCODE_W'(6'b000000): begin
        w_dec_reg_dst = 1'b1;
        w_dec_alu_src = 1'b0;
        w_dec_alu_op  = ALUOP_W'(3'b000);
      end
      OPCODE_W'(6'b000100): begin
        w_dec_mem_to_reg = 1'b1;
        w_dec_mem_read   = 1'b1;
        w_dec_alu_op     = ALUOP_W'(3'b011);
      end
      OPCODE_W'(6'b000101): begin
        w_dec_reg_write = 1'b0;
        w_dec_mem_write = 1'b1;
        w_dec_alu_op    = ALUOP_W'(3'b011);
      end
      OPCODE_W'(6'b000110): begin
        w_dec_alu_src   = 1'b0;
        w_dec_reg_write = 1'b0;
        w_dec_branch    = 1'b1;
        w_dec_alu_op    = ALUOP_W'(3'b001);
      end
      OPCODE_W'(6'b000111): begin
        w_dec_alu_op = ALUOP_W'(3'b011);
      end
      OPCODE_W'(6'b001000): begin
        w_dec_reg_dst = 1'b1;
        w_dec_alu_src = 1'b0;
        w_dec_alu_op  = ALUOP_W'(3'b100);
        w_dec_is_mul  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_lu = ex_valid & ex_mem_read & id_valid &
                ((ex_rt == id_rs) | (ex_rt == id_rt));

  // EX holds a MUL while busy, so a taken branch cannot be resolved then.
  assign mul_busy = (r_state == S_MUL_BUSY);
  assign stall    = mul_busy | (w_lu & ~branch_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_hold      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!branch_taken && !w_lu && id_valid) begin
          w_load = 1'b1;
        end
      end
      S_MUL_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_load      = id_valid;
        end else begin
          w_hold    = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_load && w_dec_is_mul) begin
      w_state_nxt = S_MUL_BUSY;
      w_cnt_nxt   = CNT_W'(MUL_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= '0;
      ex_rt         <= '0;
      ex_mul_start  <= 1'b0;
    end else if (w_hold) begin
      ex_mul_start  <= 1'b0;
    end else if (w_load) begin
      ex_valid      <= 1'b1;
      ex_reg_dst    <= w_dec_reg_dst;
      ex_alu_src    <= w_dec_alu_src;
      ex_mem_to_reg <= w_dec_mem_to_reg;
      ex_reg_write  <= w_dec_reg_write;
      ex_mem_read   <= w_dec_mem_read;
      ex_mem_write  <= w_dec_mem_write;
      ex_branch     <= w_dec_branch;
      ex_alu_op     <= w_dec_alu_op;
      ex_rt         <= id_rt;
      ex_mul_start  <= w_dec_is_mul;
    end else begin
      ex_valid      <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= '0;
      ex_rt         <= '0;
      ex_mul_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - directed self-checking bench for pipelined_control_unit
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       branch_taken = 1'b0;
  logic       stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic       ex_mem_read, ex_mem_write, ex_branch, ex_mul_start, mul_busy;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_rt;

  int n_cmp = 0;
  int n_err = 0;

  // {valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, mul_start}
  logic [11:0] ctl;
  assign ctl = {ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                ex_mem_read, ex_mem_write, ex_branch, ex_alu_op, ex_mul_start};

  localparam logic [11:0] C_BUBBLE = 12'b0000_0000_0000;
  localparam logic [11:0] C_RTYPE  = 12'b1100_1000_0000;
  localparam logic [11:0] C_LOAD   = 12'b1011_1100_0110;
  localparam logic [11:0] C_STORE  = 12'b1010_0010_0110;
  localparam logic [11:0] C_BRANCH = 12'b1000_0001_0010;
  localparam logic [11:0] C_OP7    = 12'b1010_1000_0110;
  localparam logic [11:0] C_OTHER  = 12'b1010_1000_0100;
  localparam logic [11:0] C_MUL_ST = 12'b1100_1000_1001;
  localparam logic [11:0] C_MUL_HD = 12'b1100_1000_1000;

  localparam logic [5:0] OP_R = 6'b000000, OP_LD = 6'b000100, OP_MUL = 6'b001000;

  pipelined_control_unit #(
    .OPCODE_W(6), .REG_W(5), .ALUOP_W(3), .MUL_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken), .stall(stall),
    .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_alu_op(ex_alu_op), .ex_rt(ex_rt), .ex_mul_start(ex_mul_start),
    .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (ctl !== C_BUBBLE || stall !== 1'b0 || mul_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_initial ctl=%b stall=%b busy=%b required ctl=%b stall=0 busy=0",
               ctl, stall, mul_busy, C_BUBBLE);
    end
    rst_n = 1'b1;
    drive_id(1'b1, OP_LD, 5'd0, 5'd4);
    step();
    drive_id(1'b1, OP_R, 5'd1, 5'd2);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE || ex_rt !== 5'd0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async ctl=%b rt=%0d stall=%b required ctl=%b rt=0 stall=0",
               ctl, ex_rt, stall, C_BUBBLE);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (ctl !== C_RTYPE || ex_rt !== 5'd2) begin
      n_err++;
      $display("FAIL reset_first_rtype ctl=%b rt=%0d required ctl=%b rt=2", ctl, ex_rt, C_RTYPE);
    end
  endtask

  task automatic test_decode();
    logic [5:0]  ops [7];
    logic [11:0] exp [7];
    ops = '{6'b000000, 6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b001100, 6'b111111};
    exp = '{C_RTYPE, C_LOAD, C_STORE, C_BRANCH, C_OP7, C_OTHER, C_OTHER};
    for (int i = 0; i < 7; i++) begin
      drive_id(1'b1, ops[i], 5'd0, 5'(10 + i));
      n_cmp++;
      if (stall !== 1'b0) begin
        n_err++;
        $display("FAIL decode_nostall op=%b stall=%b required 0", ops[i], stall);
      end
      step();
      n_cmp++;
      if (ctl !== exp[i] || ex_rt !== 5'(10 + i)) begin
        n_err++;
        $display("FAIL decode op=%b ctl=%b rt=%0d required ctl=%b rt=%0d",
                 ops[i], ctl, ex_rt, exp[i], 10 + i);
      end
    end
    drive_id(1'b0, OP_LD, 5'd16, 5'd16);
    step();
    n_cmp++;
    if (ctl !== C_BUBBLE) begin
      n_err++;
      $display("FAIL decode_invalid ctl=%b required %b", ctl, C_BUBBLE);
    end
  endtask

  task automatic test_load_use();
    drive_id(1'b1, OP_LD, 5'd0, 5'd5);
    step();
    drive_id(1'b1, OP_R, 5'd5, 5'd9);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL lu_stall stall=%b required 1", stall);
    end
    step();
    n_cmp++;
    if (ctl !== C_BUBBLE || stall !== 1'b0) begin
      n_err++;
      $display("FAIL lu_bubble ctl=%b stall=%b required ctl=%b stall=0", ctl, stall, C_BUBBLE);
    end
    step();
    n_cmp++;
    if (ctl !== C_RTYPE || ex_rt !== 5'd9) begin
      n_err++;
      $display("FAIL lu_add_enters ctl=%b rt=%0d required ctl=%b rt=9", ctl, ex_rt, C_RTYPE);
    end
    drive_id(1'b1, OP_LD, 5'd0, 5'd5);
    step();
    drive_id(1'b1, OP_R, 5'd6, 5'd7);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL lu_nohazard_stall stall=%b required 0", stall);
    end
    step();
    n_cmp++;
    if (ctl !== C_RTYPE || ex_rt !== 5'd7) begin
      n_err++;
      $display("FAIL lu_nohazard_add ctl=%b rt=%0d required ctl=%b rt=7", ctl, ex_rt, C_RTYPE);
    end
  endtask

  task automatic test_flush();
    drive_id(1'b1, OP_LD, 5'd0, 5'd3);
    step();
    drive_id(1'b1, OP_R, 5'd3, 5'd8);
    branch_taken = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall stall=%b required 0", stall);
    end
    step();
    branch_taken = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_BUBBLE || stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_bubble ctl=%b stall=%b required ctl=%b stall=0", ctl, stall, C_BUBBLE);
    end
    step();
    n_cmp++;
    if (ctl !== C_RTYPE) begin
      n_err++;
      $display("FAIL flush_next ctl=%b required %b", ctl, C_RTYPE);
    end
  endtask

  task automatic test_mul();
    int stall_cycles = 0;
    drive_id(1'b1, OP_MUL, 5'd1, 5'd2);
    step();
    n_cmp++;
    if (ctl !== C_MUL_ST || mul_busy !== 1'b1) begin
      n_err++;
      $display("FAIL mul_issue ctl=%b busy=%b required ctl=%b busy=1", ctl, mul_busy, C_MUL_ST);
    end
    drive_id(1'b1, OP_R, 5'd3, 5'd4);
    for (int i = 1; i <= 16; i++) begin
      if (i == 8) begin
        branch_taken = 1'b1;
        #1;
      end
      if (stall === 1'b1 && mul_busy === 1'b1) stall_cycles++;
      step();
      branch_taken = 1'b0;
      if (i < 16) begin
        n_cmp++;
        if (ctl !== C_MUL_HD || ex_rt !== 5'd2) begin
          n_err++;
          $display("FAIL mul_hold cycle=%0d ctl=%b rt=%0d required ctl=%b rt=2",
                   i, ctl, ex_rt, C_MUL_HD);
        end
      end
    end
    #1;
    n_cmp++;
    if (stall_cycles !== 16) begin
      n_err++;
      $display("FAIL mul_stall_cycles got=%0d required 16", stall_cycles);
    end
    n_cmp++;
    if (ctl !== C_RTYPE || ex_rt !== 5'd4 || mul_busy !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL mul_next ctl=%b rt=%0d busy=%b stall=%b required ctl=%b rt=4 busy=0 stall=0",
               ctl, ex_rt, mul_busy, stall, C_RTYPE);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles = 0;
    drive_id(1'b1, OP_MUL, 5'd1, 5'd2);
    step();
    n_cmp++;
    if (ctl !== C_MUL_ST) begin
      n_err++;
      $display("FAIL b2b_first_start ctl=%b required %b", ctl, C_MUL_ST);
    end
    for (int i = 1; i <= 32; i++) begin
      if (mul_busy === 1'b1) busy_cycles++;
      step();
      if (i == 16) begin
        n_cmp++;
        if (ctl !== C_MUL_ST || mul_busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_second_start ctl=%b busy=%b required ctl=%b busy=1",
                   ctl, mul_busy, C_MUL_ST);
        end
        drive_id(1'b1, OP_R, 5'd3, 5'd4);
      end else if (i == 17) begin
        n_cmp++;
        if (ctl !== C_MUL_HD) begin
          n_err++;
          $display("FAIL b2b_start_one_cycle ctl=%b required %b", ctl, C_MUL_HD);
        end
      end
    end
    n_cmp++;
    if (busy_cycles !== 32 || mul_busy !== 1'b0 || ctl !== C_RTYPE) begin
      n_err++;
      $display("FAIL b2b_end busy_cycles=%0d busy=%b ctl=%b required 32 busy=0 ctl=%b",
               busy_cycles, mul_busy, ctl, C_RTYPE);
    end
  endtask

  task automatic test_reset_mid_mul();
    drive_id(1'b1, OP_MUL, 5'd1, 5'd2);
    step();
    drive_id(1'b1, OP_R, 5'd3, 5'd4);
    for (int i = 0; i < 8; i++) step();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mul_busy !== 1'b0 || stall !== 1'b0 || ctl !== C_BUBBLE) begin
      n_err++;
      $display("FAIL rst_mid_mul busy=%b stall=%b ctl=%b required busy=0 stall=0 ctl=%b",
               mul_busy, stall, ctl, C_BUBBLE);
    end
    rst_n = 1'b1;
    drive_id(1'b1, OP_LD, 5'd0, 5'd6);
    step();
    n_cmp++;
    if (ctl !== C_LOAD || ex_rt !== 5'd6 || mul_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_mul_next ctl=%b rt=%0d busy=%b required ctl=%b rt=6 busy=0",
               ctl, ex_rt, mul_busy, C_LOAD);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_flush();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
